// File: rtl/rv_pkg.sv
// Shared types and constants for the integer register-file write side.
// The queued MDU result pairs a destination register with its data.
package rv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO for MDU results; exports count, head and a per-entry
// valid/rd view so the top level can compare against in-flight destinations.
module wb_fifo
    import rv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_push,
    input  wb_entry_t                             i_push_entry,
    input  logic                                  i_pop,
    output logic [CNT_W-1:0]                      o_count,
    output logic                                  o_empty,
    output wb_entry_t                             o_head,
    output logic [DEPTH-1:0]                      o_ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      o_ent_rd
);

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign w_push_ok = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // An entry is live when its distance from the read pointer is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [PTR_W-1:0] w_offset;
            assign w_offset        = PTR_W'(gi) - r_rd_ptr;
            assign o_ent_valid[gi] = ({1'b0, w_offset} < r_count);
            assign o_ent_rd[gi]    = r_mem[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port owner: ALU results take priority, queued MDU
// results drain in order when the ALU slot is idle; reports pending rds.
module regfile_writeback
    import rv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   aluValid,
    input  logic [REG_ADDR_W-1:0]  aluRd,
    input  logic [XLEN-1:0]        aluData,
    input  logic                   mduValid,
    output logic                   mduReady,
    input  logic [REG_ADDR_W-1:0]  mduRd,
    input  logic [XLEN-1:0]        mduData,
    input  logic [REG_ADDR_W-1:0]  addr1,
    input  logic [REG_ADDR_W-1:0]  addr2,
    output logic                   pend1,
    output logic                   pend2,
    output logic                   writeEn,
    output logic [REG_ADDR_W-1:0]  addr3,
    output logic [XLEN-1:0]        writeData,
    output logic                   wawErr
);

    logic                              r_write_en;
    logic [REG_ADDR_W-1:0]             r_addr3;
    logic [XLEN-1:0]                   r_write_data;
    logic                              r_waw_err;

    logic [CNT_W-1:0]                  w_count;
    logic                              w_empty;
    wb_entry_t                         w_head;
    wb_entry_t                         w_push_entry;
    logic [DEPTH-1:0]                  w_ent_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  w_ent_rd;
    logic                              w_ready;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_alu_take;
    logic [DEPTH-1:0]                  w_hit1;
    logic [DEPTH-1:0]                  w_hit2;
    logic [DEPTH-1:0]                  w_hit_alu;

    assign w_ready      = (w_count != CNT_W'(DEPTH));
    assign w_alu_take   = aluValid && (aluRd != REG_ZERO);
    // x0 results complete the handshake but are dropped here.
    assign w_push       = mduValid && w_ready && (mduRd != REG_ZERO);
    assign w_pop        = !w_alu_take && !w_empty;
    assign w_push_entry = '{rd: mduRd, data: mduData};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_empty      (w_empty),
        .o_head       (w_head),
        .o_ent_valid  (w_ent_valid),
        .o_ent_rd     (w_ent_rd)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_hit1[gi]    = w_ent_valid[gi] && (w_ent_rd[gi] == addr1);
            assign w_hit2[gi]    = w_ent_valid[gi] && (w_ent_rd[gi] == addr2);
            assign w_hit_alu[gi] = w_ent_valid[gi] && (w_ent_rd[gi] == aluRd);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_en   <= 1'b0;
            r_addr3      <= REG_ZERO;
            r_write_data <= '0;
            r_waw_err    <= 1'b0;
        end else begin
            if (w_alu_take) begin
                r_write_en   <= 1'b1;
                r_addr3      <= aluRd;
                r_write_data <= aluData;
            end else if (w_pop) begin
                r_write_en   <= 1'b1;
                r_addr3      <= w_head.rd;
                r_write_data <= w_head.data;
            end else begin
                r_write_en   <= 1'b0;
            end
            if (w_alu_take && (|w_hit_alu)) begin
                r_waw_err <= 1'b1;
            end
        end
    end

    assign mduReady  = w_ready;
    assign writeEn   = r_write_en;
    assign addr3     = r_addr3;
    assign writeData = r_write_data;
    assign wawErr    = r_waw_err;

    assign pend1 = (addr1 != REG_ZERO) &&
                   ((|w_hit1) || (r_write_en && (r_addr3 == addr1)));
    assign pend2 = (addr2 != REG_ZERO) &&
                   ((|w_hit2) || (r_write_en && (r_addr3 == addr2)));

endmodule
